// File: rtl/gestor_solicitudes_if.sv
// ---------------------------------------------------------------------------
// gestor_solicitudes_if
// Groups the button, cabin-position and target-handshake signals that connect
// the request manager with its environment.
//   piso_actual      : floor the cabin is at or last passed
//   boton            : level button inputs, one bit per floor
//   llegada          : one-cycle pulse, cabin stopped at piso_actual
//   siguiente_ack    : motion FSM accepts the offered target
//   siguiente_piso   : offered target floor
//   siguiente_valido : target offer valid
//   direccion        : current sweep direction (1 = up, 0 = down)
//   pendientes       : registered pending-request vector
//   ocupado          : manager not idle
//   atendidos / espera_max : statistics, present only with ESTADISTICAS_EN
// Modports: slave = request manager, master = environment / motion FSM side.
// ---------------------------------------------------------------------------
interface gestor_solicitudes_if #(
  parameter int NUM_PISOS = 4,
  parameter int PISO_W    = 2
);
  logic [PISO_W-1:0]    piso_actual;
  logic [NUM_PISOS-1:0] boton;
  logic                 llegada;
  logic                 siguiente_ack;
  logic [PISO_W-1:0]    siguiente_piso;
  logic                 siguiente_valido;
  logic                 direccion;
  logic [NUM_PISOS-1:0] pendientes;
  logic                 ocupado;
`ifdef ESTADISTICAS_EN
  logic [15:0]          atendidos;
  logic [7:0]           espera_max;
`endif

  modport slave (
`ifdef ESTADISTICAS_EN
    output atendidos,
    output espera_max,
`endif
    input  piso_actual,
    input  boton,
    input  llegada,
    input  siguiente_ack,
    output siguiente_piso,
    output siguiente_valido,
    output direccion,
    output pendientes,
    output ocupado
  );

  modport master (
`ifdef ESTADISTICAS_EN
    input  atendidos,
    input  espera_max,
`endif
    output piso_actual,
    output boton,
    output llegada,
    output siguiente_ack,
    input  siguiente_piso,
    input  siguiente_valido,
    input  direccion,
    input  pendientes,
    input  ocupado
  );
endinterface

// File: rtl/gestor_solicitudes.sv
// ---------------------------------------------------------------------------
// gestor_solicitudes
// Elevator request manager. Latches button presses into a pending vector,
// picks the next target with a SCAN policy, offers it over a valid/ack
// handshake and clears requests as the cabin stops at floors.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gestor_solicitudes_if.slave (buttons, position, handshake, status)
// Optional build macro ESTADISTICAS_EN adds the atendidos (served stops,
// saturating) and espera_max (longest offer wait, saturating) outputs.
// ---------------------------------------------------------------------------
module gestor_solicitudes #(
  parameter int NUM_PISOS = 4,
  parameter int PISO_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gestor_solicitudes_if.slave   bus
);

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    SELECCION = 2'd1,
    OFRECER   = 2'd2,
    MOVER     = 2'd3
  } estado_t;

  estado_t              r_estado;
  estado_t              w_estado_sig;

  logic [NUM_PISOS-1:0] r_boton_q;
  logic [NUM_PISOS-1:0] r_pend;
  logic [NUM_PISOS-1:0] w_nuevo;
  logic [NUM_PISOS-1:0] w_desc;
  logic [NUM_PISOS-1:0] w_clr;
  logic [NUM_PISOS-1:0] w_pend_sig;

  logic [PISO_W-1:0]    r_piso;
  logic                 r_dir;
  logic                 r_valido;

  logic [31:0]          w_p32;
  logic                 w_up_hay;
  logic [PISO_W-1:0]    w_up_idx;
  logic                 w_dn_hay;
  logic [PISO_W-1:0]    w_dn_idx;
  logic                 w_hay_obj;
  logic [PISO_W-1:0]    w_obj;
  logic                 w_obj_dir;

  assign w_p32 = 32'(bus.piso_actual);

  // Per-floor masks: clear on arrival, drop presses for the idle cabin's floor.
  // An out-of-range piso_actual matches no bit, so such arrivals are ignored.
  always_comb begin
    w_clr  = '0;
    w_desc = '0;
    for (int unsigned i = 0; i < NUM_PISOS; i++) begin
      w_clr[i]  = bus.llegada && (w_p32 == i);
      w_desc[i] = (r_estado == REPOSO) && (w_p32 == i);
    end
  end

  assign w_nuevo    = bus.boton & ~r_boton_q;
  // Clear is applied last so it wins over a same-cycle press of that floor.
  assign w_pend_sig = (r_pend | (w_nuevo & ~w_desc)) & ~w_clr;

  // Nearest pending floor above and below the cabin; the cabin's own floor is excluded.
  always_comb begin
    w_up_hay = 1'b0;
    w_up_idx = '0;
    w_dn_hay = 1'b0;
    w_dn_idx = '0;
    for (int unsigned i = 0; i < NUM_PISOS; i++) begin
      // Ascending scan: first hit above is the lowest, last hit below is the highest.
      w_up_idx = (!w_up_hay && r_pend[i] && (i > w_p32)) ? PISO_W'(i) : w_up_idx;
      w_up_hay = w_up_hay | (r_pend[i] && (i > w_p32));
      w_dn_idx = (r_pend[i] && (i < w_p32)) ? PISO_W'(i) : w_dn_idx;
      w_dn_hay = w_dn_hay | (r_pend[i] && (i < w_p32));
    end
  end

  // SCAN decision: keep the sweep direction while requests lie ahead, else reverse.
  always_comb begin
    w_hay_obj = 1'b0;
    w_obj     = r_piso;
    w_obj_dir = r_dir;
    if (r_dir) begin
      if (w_up_hay) begin
        w_hay_obj = 1'b1;
        w_obj     = w_up_idx;
        w_obj_dir = 1'b1;
      end else if (w_dn_hay) begin
        w_hay_obj = 1'b1;
        w_obj     = w_dn_idx;
        w_obj_dir = 1'b0;
      end else begin
        w_hay_obj = 1'b0;
      end
    end else begin
      if (w_dn_hay) begin
        w_hay_obj = 1'b1;
        w_obj     = w_dn_idx;
        w_obj_dir = 1'b0;
      end else if (w_up_hay) begin
        w_hay_obj = 1'b1;
        w_obj     = w_up_idx;
        w_obj_dir = 1'b1;
      end else begin
        w_hay_obj = 1'b0;
      end
    end
  end

  // Next-state logic of the request FSM.
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      REPOSO: begin
        if (r_pend != '0) w_estado_sig = SELECCION;
        else              w_estado_sig = REPOSO;
      end
      SELECCION: begin
        if (w_hay_obj) w_estado_sig = OFRECER;
        else           w_estado_sig = REPOSO;
      end
      OFRECER: begin
        if (bus.siguiente_ack) w_estado_sig = MOVER;
        else                   w_estado_sig = OFRECER;
      end
      MOVER: begin
        // Only arrival at the accepted target ends the move; other stops just clear.
        if (bus.llegada && (bus.piso_actual == r_piso)) begin
          if (w_pend_sig != '0) w_estado_sig = SELECCION;
          else                  w_estado_sig = REPOSO;
        end else begin
          w_estado_sig = MOVER;
        end
      end
      default: w_estado_sig = REPOSO;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= REPOSO;
    else        r_estado <= w_estado_sig;
  end

  // Button history and pending vector; history resets to ones so held buttons are not seen as presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boton_q <= '1;
      r_pend    <= '0;
    end else begin
      r_boton_q <= bus.boton;
      r_pend    <= w_pend_sig;
    end
  end

  // Offer registers: target and direction are frozen from selection until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_piso   <= '0;
      r_dir    <= 1'b1;
      r_valido <= 1'b0;
    end else if ((r_estado == SELECCION) && w_hay_obj) begin
      r_piso   <= w_obj;
      r_dir    <= w_obj_dir;
      r_valido <= 1'b1;
    end else if ((r_estado == OFRECER) && bus.siguiente_ack) begin
      r_valido <= 1'b0;
    end
  end

  assign bus.siguiente_piso   = r_piso;
  assign bus.siguiente_valido = r_valido;
  assign bus.direccion        = r_dir;
  assign bus.pendientes       = r_pend;
  assign bus.ocupado          = (r_estado != REPOSO);

`ifdef ESTADISTICAS_EN
  logic [15:0] r_atendidos;
  logic [7:0]  r_espera;
  logic [7:0]  r_espera_max;

  // Served-stop counter: an arrival counts only if it clears a bit that was pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_atendidos <= 16'h0000;
    end else if (((w_clr & r_pend) != '0) && (r_atendidos != 16'hFFFF)) begin
      r_atendidos <= r_atendidos + 16'h0001;
    end
  end

  // Offer wait: cycles with valid high before the ack cycle, keeping the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_espera     <= 8'h00;
      r_espera_max <= 8'h00;
    end else if (r_estado == SELECCION) begin
      r_espera <= 8'h00;
    end else if (r_estado == OFRECER) begin
      if (bus.siguiente_ack) begin
        if (r_espera > r_espera_max) r_espera_max <= r_espera;
      end else if (r_espera != 8'hFF) begin
        r_espera <= r_espera + 8'h01;
      end
    end
  end

  assign bus.atendidos  = r_atendidos;
  assign bus.espera_max = r_espera_max;
`else
  // Statistics disabled: no extra ports or logic.
`endif

endmodule

// File: tb/tb_gestor_solicitudes.sv
// ---------------------------------------------------------------------------
// tb_gestor_solicitudes
// Directed bench for gestor_solicitudes (NUM_PISOS=4, PISO_W=2). Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_gestor_solicitudes;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  gestor_solicitudes_if #(.NUM_PISOS(4), .PISO_W(2)) bus ();

  gestor_solicitudes #(.NUM_PISOS(4), .PISO_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.boton         = 4'b0000;
    bus.llegada       = 1'b0;
    bus.siguiente_ack = 1'b0;
    bus.piso_actual   = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Values while in reset and right after release.
  task automatic test_reset();
    rst_n = 1'b0;
    bus.boton = 4'b0000; bus.llegada = 1'b0; bus.siguiente_ack = 1'b0; bus.piso_actual = 2'd0;
    @(negedge clk);
    n_total++;
    if ({bus.siguiente_valido, bus.siguiente_piso, bus.direccion, bus.pendientes, bus.ocupado} !== 9'b0_00_1_0000_0)
      $display("FAIL reset_in: got %b expected %b",
        {bus.siguiente_valido, bus.siguiente_piso, bus.direccion, bus.pendientes, bus.ocupado}, 9'b0_00_1_0000_0);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.siguiente_valido, bus.siguiente_piso, bus.direccion, bus.pendientes, bus.ocupado} !== 9'b0_00_1_0000_0)
      $display("FAIL reset_out: got %b expected %b",
        {bus.siguiente_valido, bus.siguiente_piso, bus.direccion, bus.pendientes, bus.ocupado}, 9'b0_00_1_0000_0);
    else n_pass++;
  endtask

  // Button held through reset is not a press; a fresh press is.
  task automatic test_held_button();
    rst_n = 1'b0; bus.piso_actual = 2'd0; bus.boton = 4'b0010;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.pendientes, bus.siguiente_valido} !== 5'b0000_0)
      $display("FAIL held_button: got %b expected %b", {bus.pendientes, bus.siguiente_valido}, 5'b0000_0);
    else n_pass++;
    bus.boton = 4'b0000;
    @(negedge clk);
    bus.boton = 4'b0010;
    @(negedge clk);
    bus.boton = 4'b0000;
    n_total++;
    if (bus.pendientes !== 4'b0010)
      $display("FAIL repress: got %b expected %b", bus.pendientes, 4'b0010);
    else n_pass++;
  endtask

  // Two presses at once from floor 0, serve 2 then 3; checks offer latency.
  task automatic test_scan_up();
    do_reset();
    bus.piso_actual = 2'd0; bus.boton = 4'b1100;
    @(negedge clk);
    bus.boton = 4'b0000;
    n_total++;
    if ({bus.pendientes, bus.siguiente_valido} !== 5'b1100_0)
      $display("FAIL latch_2_3: got %b expected %b", {bus.pendientes, bus.siguiente_valido}, 5'b1100_0);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.siguiente_valido, bus.ocupado} !== 2'b01)
      $display("FAIL seleccion: got %b expected %b", {bus.siguiente_valido, bus.ocupado}, 2'b01);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.siguiente_valido, bus.siguiente_piso, bus.direccion} !== 4'b1_10_1)
      $display("FAIL offer_2: got %b expected %b", {bus.siguiente_valido, bus.siguiente_piso, bus.direccion}, 4'b1_10_1);
    else n_pass++;
    bus.siguiente_ack = 1'b1;
    @(negedge clk);
    bus.siguiente_ack = 1'b0;
    n_total++;
    if ({bus.siguiente_valido, bus.ocupado} !== 2'b01)
      $display("FAIL ack_drop: got %b expected %b", {bus.siguiente_valido, bus.ocupado}, 2'b01);
    else n_pass++;
    bus.piso_actual = 2'd2; bus.llegada = 1'b1;
    @(negedge clk);
    bus.llegada = 1'b0;
    n_total++;
    if (bus.pendientes !== 4'b1000)
      $display("FAIL clear_2: got %b expected %b", bus.pendientes, 4'b1000);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.siguiente_valido, bus.siguiente_piso, bus.direccion} !== 4'b1_11_1)
      $display("FAIL offer_3: got %b expected %b", {bus.siguiente_valido, bus.siguiente_piso, bus.direccion}, 4'b1_11_1);
    else n_pass++;
  endtask

  // From floor 2 going up with 0 and 3 pending: 3 first, then reverse to 0.
  task automatic test_scan_reverse();
    do_reset();
    bus.piso_actual = 2'd2; bus.boton = 4'b1001;
    @(negedge clk);
    bus.boton = 4'b0000;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.siguiente_valido, bus.siguiente_piso, bus.direccion} !== 4'b1_11_1)
      $display("FAIL rev_offer_3: got %b expected %b", {bus.siguiente_valido, bus.siguiente_piso, bus.direccion}, 4'b1_11_1);
    else n_pass++;
    bus.siguiente_ack = 1'b1;
    @(negedge clk);
    bus.siguiente_ack = 1'b0;
    bus.piso_actual = 2'd3; bus.llegada = 1'b1;
    @(negedge clk);
    bus.llegada = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.siguiente_valido, bus.siguiente_piso, bus.direccion, bus.pendientes} !== 8'b1_00_0_0001)
      $display("FAIL rev_offer_0: got %b expected %b",
        {bus.siguiente_valido, bus.siguiente_piso, bus.direccion, bus.pendientes}, 8'b1_00_0_0001);
    else n_pass++;
  endtask

  // Intermediate stop at floor 1 with a same-cycle press of floor 1.
  task automatic test_clear_beats_set();
    do_reset();
    bus.piso_actual = 2'd0; bus.boton = 4'b1000;
    @(negedge clk);
    bus.boton = 4'b0000;
    repeat (2) @(negedge clk);
    bus.siguiente_ack = 1'b1;
    @(negedge clk);
    bus.siguiente_ack = 1'b0;
    bus.piso_actual = 2'd1; bus.llegada = 1'b1; bus.boton = 4'b0010;
    @(negedge clk);
    bus.llegada = 1'b0; bus.boton = 4'b0000;
    n_total++;
    if ({bus.pendientes, bus.ocupado, bus.siguiente_valido} !== 6'b1000_1_0)
      $display("FAIL clear_beats_set: got %b expected %b",
        {bus.pendientes, bus.ocupado, bus.siguiente_valido}, 6'b1000_1_0);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({bus.ocupado, bus.siguiente_valido} !== 2'b10)
      $display("FAIL stay_mover: got %b expected %b", {bus.ocupado, bus.siguiente_valido}, 2'b10);
    else n_pass++;
  endtask

  // Offer stays frozen while ack is withheld, even with a nearer request.
  task automatic test_offer_hold();
    do_reset();
    bus.piso_actual = 2'd0; bus.boton = 4'b1000;
    @(negedge clk);
    bus.boton = 4'b0000;
    repeat (2) @(negedge clk);
    bus.boton = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.boton = 4'b0000;
      n_total++;
      if ({bus.siguiente_valido, bus.siguiente_piso, bus.direccion} !== 4'b1_11_1)
        $display("FAIL hold_%0d: got %b expected %b", k,
          {bus.siguiente_valido, bus.siguiente_piso, bus.direccion}, 4'b1_11_1);
      else n_pass++;
    end
    n_total++;
    if (bus.pendientes !== 4'b1010)
      $display("FAIL hold_pend: got %b expected %b", bus.pendientes, 4'b1010);
    else n_pass++;
    bus.siguiente_ack = 1'b1;
    @(negedge clk);
    bus.siguiente_ack = 1'b0;
    bus.piso_actual = 2'd3; bus.llegada = 1'b1;
    @(negedge clk);
    bus.llegada = 1'b0;
    n_total++;
    if (bus.pendientes !== 4'b0010)
      $display("FAIL hold_clear_3: got %b expected %b", bus.pendientes, 4'b0010);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.siguiente_valido, bus.siguiente_piso, bus.direccion} !== 4'b1_01_0)
      $display("FAIL hold_offer_1: got %b expected %b", {bus.siguiente_valido, bus.siguiente_piso, bus.direccion}, 4'b1_01_0);
    else n_pass++;
  endtask

  // Idle press at the cabin's floor is dropped; ack outside an offer does nothing.
  task automatic test_discard_and_stray_ack();
    do_reset();
    bus.piso_actual = 2'd2; bus.boton = 4'b0100; bus.siguiente_ack = 1'b1;
    @(negedge clk);
    bus.boton = 4'b0000;
    @(negedge clk);
    bus.siguiente_ack = 1'b0;
    n_total++;
    if ({bus.pendientes, bus.ocupado, bus.siguiente_valido} !== 6'b0000_0_0)
      $display("FAIL discard: got %b expected %b", {bus.pendientes, bus.ocupado, bus.siguiente_valido}, 6'b0000_0_0);
    else n_pass++;
  endtask

  // Reset asserted mid-offer clears everything without waiting for a clock.
  task automatic test_reset_abort();
    do_reset();
    bus.piso_actual = 2'd0; bus.boton = 4'b0010;
    @(negedge clk);
    bus.boton = 4'b0000;
    repeat (2) @(negedge clk);
    n_total++;
    if (bus.siguiente_valido !== 1'b1)
      $display("FAIL abort_pre: got %b expected %b", bus.siguiente_valido, 1'b1);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.siguiente_valido, bus.pendientes, bus.ocupado} !== 6'b0_0000_0)
      $display("FAIL abort: got %b expected %b", {bus.siguiente_valido, bus.pendientes, bus.ocupado}, 6'b0_0000_0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef ESTADISTICAS_EN
  // Three served stops with ack delays 0, 4 and 2 cycles.
  task automatic test_estadisticas();
    logic [3:0] pisos [3];
    int         esperas [3];
    pisos[0] = 4'b0010; pisos[1] = 4'b0100; pisos[2] = 4'b1000;
    esperas[0] = 0; esperas[1] = 4; esperas[2] = 2;
    do_reset();
    bus.piso_actual = 2'd0;
    for (int k = 0; k < 3; k++) begin
      bus.boton = pisos[k];
      @(negedge clk);
      bus.boton = 4'b0000;
      repeat (2) @(negedge clk);
      n_total++;
      if (bus.siguiente_valido !== 1'b1)
        $display("FAIL stats_offer_%0d: got %b expected %b", k, bus.siguiente_valido, 1'b1);
      else n_pass++;
      repeat (esperas[k]) @(negedge clk);
      bus.siguiente_ack = 1'b1;
      @(negedge clk);
      bus.siguiente_ack = 1'b0;
      bus.piso_actual = 2'(k + 1); bus.llegada = 1'b1;
      @(negedge clk);
      bus.llegada = 1'b0;
    end
    n_total++;
    if ({bus.atendidos, bus.espera_max} !== {16'd3, 8'd4})
      $display("FAIL stats: got %0d/%0d expected 3/4", bus.atendidos, bus.espera_max);
    else n_pass++;
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    n_pass = 0;
    n_total = 0;
    bus.boton = 4'b0000;
    bus.llegada = 1'b0;
    bus.siguiente_ack = 1'b0;
    bus.piso_actual = 2'd0;
    test_reset();
    test_held_button();
    test_scan_up();
    test_scan_reverse();
    test_clear_beats_set();
    test_offer_hold();
    test_discard_and_stray_ack();
    test_reset_abort();
`ifdef ESTADISTICAS_EN
    test_estadisticas();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gestor_solicitudes.md
Name: gestor_solicitudes

Overview:
- Parametrised elevator request manager for NUM_PISOS floors; successor to the single-instruction request memory.
- Latches button presses into a pending-request vector and chooses the next target floor with a SCAN policy (keep direction while requests remain ahead, else reverse).
- Offers that target to the elevator state machine over a valid/ack handshake, then clears requests as the cabin stops at floors.
- Sits between the button inputs and the elevator motion FSM.

Parameters:
NUM_PISOS, 4, number of floors (2..16)
PISO_W, 2, floor-index width; must satisfy 2**PISO_W >= NUM_PISOS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
piso_actual  input  PISO_W  floor the cabin is at or last passed
boton  input  NUM_PISOS  level button inputs, one bit per floor
llegada  input  1  one-cycle pulse: cabin stopped at piso_actual
siguiente_ack  input  1  motion FSM accepts the offered target
siguiente_piso  output  PISO_W  offered target floor
siguiente_valido  output  1  target offer valid
direccion  output  1  current sweep direction, 1=up, 0=down
pendientes  output  NUM_PISOS  registered pending-request vector
ocupado  output  1  state != REPOSO

Behaviour:
- Reset (async assert, sync release) sets:
  - siguiente_piso=0, siguiente_valido=0, direccion=1, pendientes=0, state REPOSO.
  - Internal boton_q = all ones, so buttons held through reset do not register.
- Press detection: nuevo = boton & ~boton_q; boton_q <= boton every cycle. Each nuevo[i] sets pendientes[i] at the same edge.
- Clearing:
  - llegada with piso_actual < NUM_PISOS clears pendientes[piso_actual].
  - Clear beats a same-cycle set of that bit.
  - llegada with piso_actual >= NUM_PISOS is ignored.
- Discard: a press for piso_actual while in REPOSO is dropped (cabin already there).
- FSM:
  - REPOSO: pendientes != 0 -> SELECCION.
  - SELECCION (1 cycle): compute target per the SCAN rules below and register siguiente_piso/direccion -> OFRECER. If no candidate exists (all bits cleared meanwhile) -> REPOSO.
  - OFRECER: siguiente_valido=1.
    - siguiente_piso and direccion are held stable until ack, even if a nearer request arrives.
    - siguiente_ack -> MOVER; valid drops at that edge.
  - MOVER: wait for llegada.
    - llegada at siguiente_piso -> SELECCION if pendientes (after clear) != 0, else REPOSO.
    - llegada elsewhere: clear that floor, stay in MOVER.
- SCAN selection (p = piso_actual):
  - direccion=1: if any pending above p, target = lowest pending index > p, direccion stays 1. Else if any below, target = highest pending index < p, direccion=0.
  - direccion=0: mirror image.
  - A pending bit at p itself is never a target; it is cleared by the next llegada.
- Latency: press sampled at edge t -> pendientes at t -> SELECCION at t+1 -> siguiente_valido=1 after edge t+2.
- Ack while not in OFRECER is ignored.
- Reset mid-operation aborts any offer immediately; all pending requests are lost.

Optional Feature:
- Macro ESTADISTICAS_EN.
- Defined:
  - Adds output atendidos [15:0], reset 0.
  - Increments on each llegada that clears a bit that was set; saturates at 16'hFFFF.
  - Adds output espera_max [7:0]: longest number of cycles siguiente_valido stayed high before ack, saturating at 255, reset 0.
- Undefined: neither port nor their logic exists; all other behaviour is identical.

Test Plan:
- rst_n low with boton=4'b0010 held, release -> pendientes=0, valid=0; drop boton, press bit1 again -> pendientes=4'b0010.
- piso_actual=0, press floors 2 and 3 in the same cycle -> valid=1 two edges later, siguiente_piso=2, direccion=1; ack, llegada at 2 -> pendientes=4'b1000, new offer siguiente_piso=3.
- piso_actual=2, direccion=1, pending floors 0 and 3 -> offer 3; llegada at 3 -> offer 0 with direccion=0.
- In MOVER, llegada at floor 1 while boton[1] rises in the same cycle -> pendientes[1]=0, state stays MOVER.
- Offering floor 3 from floor 0, press floor 1 with ack held low for 5 cycles -> siguiente_piso stays 3, pendientes[1]=1; after ack and llegada at 3 -> offer 1, direccion=0.
- ESTADISTICAS_EN: 3 served stops with ack delays of 0, 4 and 2 cycles -> atendidos=3, espera_max=4.
